// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the HD44780-style LCD bus scheduler.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_LINE0     = 8'h80;
  localparam logic [7:0] CMD_LINE1     = 8'hC0;

  localparam int unsigned INIT_LEN = 4;
  localparam int unsigned INIT_W   = 2;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT,
    ST_IDLE,
    ST_WRAP
  } lcd_state_t;

  // Byte presented on the LCD pins together with its register select.
  typedef struct packed {
    logic       rs;
    logic [7:0] din;
  } lcd_bus_t;

  function automatic logic [7:0] init_byte(input logic [INIT_W-1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_8B2L;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY_INC;
    endcase
  endfunction

  // Clear and home need the long post-strobe wait.
  function automatic logic is_long_cmd(input logic [7:0] d);
    return (d == 8'h01) || (d == 8'h02) || (d == 8'h03);
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Loadable down-counter shared by every timed phase; done pulses one cycle after reaching 0,
// so loading K-2 yields a phase exactly K cycles long (K >= 2).
module lcd_strobe_timer #(
  parameter int unsigned     CNT_W   = 20,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;

  // Reset starts the power-up interval immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= RST_VAL;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= val_i;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      done_q <= (cnt_q == '0);
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Power-on init, command/character arbitration, EN strobe timing and cursor wrap
// for an 8-bit HD44780-style character LCD.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned EN_CYC    = 25,
  parameter int unsigned WAIT_CYC  = 2500,
  parameter int unsigned LONG_CYC  = 100000,
  parameter int unsigned PWRUP_CYC = 1000000,
  parameter int unsigned COLS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       chr_valid,
  input  logic [7:0] chr_data,
  output logic       chr_ready,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] lcd_din,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int unsigned MAX_CYC = umax(umax(umax(PWRUP_CYC, LONG_CYC), umax(WAIT_CYC, EN_CYC)),
                                         SETUP_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned COL_W   = 6;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 2);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 2);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 2);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 2);
  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 2);
  localparam logic [COL_W-1:0] COLS_V   = COL_W'(COLS);

  lcd_state_t        state_q;
  lcd_bus_t          bus_q;
  logic              en_q;
  logic              rdy_q;
  logic              init_done_q;
  logic              busy_q;
  logic [COL_W-1:0]  col_q;
  logic              line_q;
  logic              wrap_q;
  logic              long_q;
  logic [INIT_W-1:0] idx_q;

  logic              acc_cmd_c;
  logic              acc_chr_c;
  logic              tmr_load_c;
  logic [CNT_W-1:0]  tmr_val_c;
  logic              tmr_done;

  lcd_strobe_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(PWRUP_LD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load_i(tmr_load_c),
    .val_i (tmr_val_c),
    .done_o(tmr_done)
  );

  // Handshakes and timer reloads on every phase boundary.
  always_comb begin
    acc_cmd_c  = rdy_q & cmd_valid;
    acc_chr_c  = rdy_q & ~cmd_valid & chr_valid;
    tmr_load_c = 1'b0;
    tmr_val_c  = SETUP_LD;
    case (state_q)
      ST_INIT, ST_WRAP: tmr_load_c = 1'b1;
      ST_IDLE:          tmr_load_c = acc_cmd_c | acc_chr_c;
      ST_SETUP: begin
        tmr_load_c = tmr_done;
        tmr_val_c  = EN_LD;
      end
      ST_PULSE: begin
        tmr_load_c = tmr_done;
        tmr_val_c  = long_q ? LONG_LD : WAIT_LD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PWRUP;
      bus_q       <= '0;
      en_q        <= 1'b0;
      rdy_q       <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      col_q       <= '0;
      line_q      <= 1'b0;
      wrap_q      <= 1'b0;
      long_q      <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        ST_PWRUP: if (tmr_done) state_q <= ST_INIT;
        ST_INIT: begin
          bus_q   <= '{rs: 1'b0, din: init_byte(idx_q)};
          long_q  <= is_long_cmd(init_byte(idx_q));
          state_q <= ST_SETUP;
        end
        ST_IDLE: begin
          if (wrap_q) begin
            state_q <= ST_WRAP;
            busy_q  <= 1'b1;
          end else if (acc_cmd_c) begin
            bus_q   <= '{rs: 1'b0, din: cmd_data};
            long_q  <= is_long_cmd(cmd_data);
            state_q <= ST_SETUP;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (is_long_cmd(cmd_data)) begin
              col_q  <= '0;
              line_q <= 1'b0;
            end else if (cmd_data[7]) begin
              line_q <= cmd_data[6];
              col_q  <= cmd_data[5:0];
              wrap_q <= (cmd_data[5:0] >= COLS_V);
            end
          end else if (acc_chr_c) begin
            bus_q   <= '{rs: 1'b1, din: chr_data};
            long_q  <= 1'b0;
            state_q <= ST_SETUP;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            col_q   <= col_q + COL_W'(1);
            wrap_q  <= ((col_q + COL_W'(1)) == COLS_V);
          end
        end
        // Move the DDRAM address to the start of the other line.
        ST_WRAP: begin
          bus_q   <= '{rs: 1'b0, din: (line_q ? CMD_LINE0 : CMD_LINE1)};
          long_q  <= 1'b0;
          line_q  <= ~line_q;
          col_q   <= '0;
          wrap_q  <= 1'b0;
          state_q <= ST_SETUP;
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state_q <= ST_PULSE;
            en_q    <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (tmr_done) begin
            state_q <= ST_WAIT;
            en_q    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (tmr_done) begin
            if (!init_done_q) begin
              if (idx_q == INIT_W'(INIT_LEN - 1)) begin
                init_done_q <= 1'b1;
                col_q       <= '0;
                line_q      <= 1'b0;
                wrap_q      <= 1'b0;
                state_q     <= ST_IDLE;
                rdy_q       <= 1'b1;
                busy_q      <= 1'b0;
              end else begin
                idx_q   <= idx_q + INIT_W'(1);
                state_q <= ST_INIT;
              end
            end else begin
              state_q <= ST_IDLE;
              rdy_q   <= ~wrap_q;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_PWRUP;
      endcase
    end
  end

  assign lcd_din   = bus_q.din;
  assign lcd_rs    = bus_q.rs;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = en_q;
  assign cmd_ready = rdy_q;
  assign chr_ready = rdy_q & ~cmd_valid;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler with shortened timing parameters.
module tb_lcd_bus_scheduler;

  localparam int unsigned SETUP_CYC = 2;
  localparam int unsigned EN_CYC    = 3;
  localparam int unsigned WAIT_CYC  = 5;
  localparam int unsigned LONG_CYC  = 20;
  localparam int unsigned PWRUP_CYC = 10;
  localparam int unsigned COLS      = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       chr_valid = 1'b0;
  logic [7:0] chr_data = 8'h00;
  logic       chr_ready;
  logic       init_done;
  logic       busy;
  logic [7:0] lcd_din;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  lcd_bus_scheduler #(
    .SETUP_CYC(SETUP_CYC),
    .EN_CYC   (EN_CYC),
    .WAIT_CYC (WAIT_CYC),
    .LONG_CYC (LONG_CYC),
    .PWRUP_CYC(PWRUP_CYC),
    .COLS     (COLS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .chr_valid(chr_valid),
    .chr_data (chr_data),
    .chr_ready(chr_ready),
    .init_done(init_done),
    .busy     (busy),
    .lcd_din  (lcd_din),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: one record per completed EN pulse.
  typedef struct {
    logic [7:0] din;
    logic       rs;
    int         rise;
    int         fall;
    logic       stable;
  } strobe_t;

  strobe_t mon[256];
  strobe_t cur;
  int      n_str = 0;
  logic    en_prev = 1'b0;

  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      cur.din    = lcd_din;
      cur.rs     = lcd_rs;
      cur.rise   = cyc;
      cur.stable = 1'b1;
    end else if (lcd_en) begin
      if (lcd_din !== cur.din || lcd_rs !== cur.rs) cur.stable = 1'b0;
    end else if (en_prev) begin
      cur.fall = cyc;
      if (n_str < 256) mon[n_str] = cur;
      n_str++;
    end
    en_prev = lcd_en;
  end

  typedef struct {
    logic       is_cmd;
    logic [7:0] data;
    logic [7:0] exp_din;
    logic       exp_rs;
    int         lat;   // accept -> ready again; 0 when a wrap is inserted
    logic [7:0] wrap;  // inserted address byte, 0 when none
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs[NVEC];
  logic [7:0] init_seq[4];
  int init_gap[3];

  int n_chk = 0;
  int n_err = 0;
  int rd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_ready(input string nm, output int r);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    if (cmd_ready !== 1'b1) fail_to(nm);
    r = cyc;
  endtask

  // Releases reset (caller holds it) and checks the whole init sequence.
  task automatic run_init();
    int base, t, done_cyc;
    base = cyc;
    rst  = 1'b0;
    t = 0;
    while (init_done !== 1'b1 && t < 400) begin
      step();
      t++;
    end
    if (init_done !== 1'b1) begin
      fail_to("init_done");
      rd = n_str;
      return;
    end
    done_cyc = cyc;
    chk("init strobe count", 32'(n_str - rd), 32'd4);
    chk("init first en rise", 32'(mon[rd].rise - base), 32'(PWRUP_CYC + 1 + SETUP_CYC));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("init byte %0d din", i), 32'(mon[rd+i].din), 32'(init_seq[i]));
      chk($sformatf("init byte %0d rs", i), 32'(mon[rd+i].rs), 32'd0);
      chk($sformatf("init byte %0d en width", i), 32'(mon[rd+i].fall - mon[rd+i].rise), 32'(EN_CYC));
      chk($sformatf("init byte %0d stable", i), 32'(mon[rd+i].stable), 32'd1);
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("init gap after byte %0d", i), 32'(mon[rd+i+1].rise - mon[rd+i].fall),
          32'(init_gap[i]));
    chk("init_done after last wait", 32'(done_cyc - mon[rd+3].fall), 32'(WAIT_CYC));
    chk("idle busy after init", 32'(busy), 32'd0);
    chk("idle cmd_ready after init", 32'(cmd_ready), 32'd1);
    rd = n_str;
  endtask

  // Presents one request and returns the cycle in which it was accepted.
  task automatic xfer(input logic is_cmd, input logic [7:0] d, output int n_acc, output logic ok);
    ok        = 1'b0;
    n_acc     = 0;
    cmd_valid = is_cmd;
    cmd_data  = d;
    chr_valid = ~is_cmd;
    chr_data  = d;
    for (int t = 0; t < 300; t++) begin
      #1;
      if ((is_cmd ? cmd_ready : chr_ready) === 1'b1) begin
        ok    = 1'b1;
        n_acc = cyc;
        break;
      end
      step();
    end
    step();
    cmd_valid = 1'b0;
    chr_valid = 1'b0;
  endtask

  initial begin
    int n, r, a, t;
    logic ok;
    string nm;

    init_seq = '{8'h38, 8'h0C, 8'h01, 8'h06};
    init_gap = '{WAIT_CYC + 1 + SETUP_CYC, WAIT_CYC + 1 + SETUP_CYC, LONG_CYC + 1 + SETUP_CYC};

    vecs[0]  = '{1'b1, 8'h80, 8'h80, 1'b0, 11, 8'h00};
    vecs[1]  = '{1'b0, 8'h48, 8'h48, 1'b1, 11, 8'h00};
    vecs[2]  = '{1'b1, 8'h0C, 8'h0C, 1'b0, 11, 8'h00};
    vecs[3]  = '{1'b1, 8'h80, 8'h80, 1'b0, 11, 8'h00};
    vecs[4]  = '{1'b0, 8'h41, 8'h41, 1'b1, 11, 8'h00};
    vecs[5]  = '{1'b0, 8'h42, 8'h42, 1'b1, 11, 8'h00};
    vecs[6]  = '{1'b0, 8'h43, 8'h43, 1'b1, 11, 8'h00};
    vecs[7]  = '{1'b0, 8'h44, 8'h44, 1'b1, 0,  8'hC0};
    vecs[8]  = '{1'b0, 8'h45, 8'h45, 1'b1, 11, 8'h00};
    vecs[9]  = '{1'b0, 8'h46, 8'h46, 1'b1, 11, 8'h00};
    vecs[10] = '{1'b0, 8'h47, 8'h47, 1'b1, 11, 8'h00};
    vecs[11] = '{1'b0, 8'h48, 8'h48, 1'b1, 0,  8'h80};
    vecs[12] = '{1'b0, 8'h41, 8'h41, 1'b1, 11, 8'h00};
    vecs[13] = '{1'b0, 8'h42, 8'h42, 1'b1, 11, 8'h00};
    vecs[14] = '{1'b1, 8'h01, 8'h01, 1'b0, 26, 8'h00};
    vecs[15] = '{1'b0, 8'h43, 8'h43, 1'b1, 11, 8'h00};
    vecs[16] = '{1'b0, 8'h44, 8'h44, 1'b1, 11, 8'h00};
    vecs[17] = '{1'b0, 8'h45, 8'h45, 1'b1, 11, 8'h00};
    vecs[18] = '{1'b0, 8'h46, 8'h46, 1'b1, 0,  8'hC0};
    vecs[19] = '{1'b1, 8'h85, 8'h85, 1'b0, 0,  8'hC0};
    vecs[20] = '{1'b1, 8'h02, 8'h02, 1'b0, 26, 8'h00};
    vecs[21] = '{1'b1, 8'hC3, 8'hC3, 1'b0, 11, 8'h00};
    vecs[22] = '{1'b0, 8'h5A, 8'h5A, 1'b1, 0,  8'h80};
    vecs[23] = '{1'b0, 8'h31, 8'h31, 1'b1, 11, 8'h00};

    // Reset state
    step();
    step();
    chk("reset lcd_din", 32'(lcd_din), 32'h00);
    chk("reset lcd_rs", 32'(lcd_rs), 32'd0);
    chk("reset lcd_rw", 32'(lcd_rw), 32'd0);
    chk("reset lcd_en", 32'(lcd_en), 32'd0);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset chr_ready", 32'(chr_ready), 32'd0);
    chk("reset init_done", 32'(init_done), 32'd0);
    chk("reset busy", 32'(busy), 32'd1);

    run_init();

    // Simultaneous requests: command first, character at the next IDLE
    cmd_valid = 1'b1;
    cmd_data  = 8'h0C;
    chr_valid = 1'b1;
    chr_data  = 8'h41;
    #1;
    chk("prio cmd_ready", 32'(cmd_ready), 32'd1);
    chk("prio chr_ready low", 32'(chr_ready), 32'd0);
    n = cyc;
    step();
    cmd_valid = 1'b0;
    chk("prio cmd din", 32'(lcd_din), 32'h0C);
    chk("prio cmd rs", 32'(lcd_rs), 32'd0);
    a = -1;
    for (t = 0; t < 100; t++) begin
      #1;
      if (chr_ready === 1'b1) begin
        a = cyc;
        break;
      end
      step();
    end
    if (a < 0) fail_to("prio chr accept");
    else chk("prio chr accept cycle", 32'(a - n), 32'(1 + SETUP_CYC + EN_CYC + WAIT_CYC));
    step();
    chr_valid = 1'b0;
    chk("prio chr din", 32'(lcd_din), 32'h41);
    chk("prio chr rs", 32'(lcd_rs), 32'd1);
    wait_ready("prio ready return", r);
    chk("prio strobe count", 32'(n_str - rd), 32'd2);
    rd = n_str;

    // Table of single transfers
    for (int i = 0; i < NVEC; i++) begin
      xfer(vecs[i].is_cmd, vecs[i].data, n, ok);
      if (!ok) begin
        fail_to($sformatf("vec%0d accept", i));
        rd = n_str;
        continue;
      end
      chk($sformatf("vec%0d din at N+1", i), 32'(lcd_din), 32'(vecs[i].exp_din));
      chk($sformatf("vec%0d rs at N+1", i), 32'(lcd_rs), 32'(vecs[i].exp_rs));
      chk($sformatf("vec%0d rw", i), 32'(lcd_rw), 32'd0);
      chk($sformatf("vec%0d busy at N+1", i), 32'(busy), 32'd1);
      wait_ready($sformatf("vec%0d ready return", i), r);
      if (vecs[i].lat != 0)
        chk($sformatf("vec%0d ready latency", i), 32'(r - n), 32'(vecs[i].lat));
      chk($sformatf("vec%0d strobe count", i), 32'(n_str - rd),
          (vecs[i].wrap != 8'h00) ? 32'd2 : 32'd1);
      chk($sformatf("vec%0d strobe din", i), 32'(mon[rd].din), 32'(vecs[i].exp_din));
      chk($sformatf("vec%0d strobe rs", i), 32'(mon[rd].rs), 32'(vecs[i].exp_rs));
      chk($sformatf("vec%0d en rise", i), 32'(mon[rd].rise - n), 32'(1 + SETUP_CYC));
      chk($sformatf("vec%0d en width", i), 32'(mon[rd].fall - mon[rd].rise), 32'(EN_CYC));
      chk($sformatf("vec%0d bus stable", i), 32'(mon[rd].stable), 32'd1);
      if (vecs[i].wrap != 8'h00) begin
        nm = $sformatf("vec%0d wrap", i);
        chk({nm, " din"}, 32'(mon[rd+1].din), 32'(vecs[i].wrap));
        chk({nm, " rs"}, 32'(mon[rd+1].rs), 32'd0);
        chk({nm, " en width"}, 32'(mon[rd+1].fall - mon[rd+1].rise), 32'(EN_CYC));
      end
      rd = n_str;
    end

    // Reset while EN is high, then a full replay of init
    xfer(1'b0, 8'h55, n, ok);
    if (!ok) fail_to("mid-strobe accept");
    t = 0;
    while (lcd_en !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    if (lcd_en !== 1'b1) fail_to("mid-strobe en");
    rst = 1'b1;
    #1;
    chk("async rst lcd_en", 32'(lcd_en), 32'd0);
    chk("async rst init_done", 32'(init_done), 32'd0);
    chk("async rst busy", 32'(busy), 32'd1);
    chk("async rst lcd_din", 32'(lcd_din), 32'h00);
    chk("async rst cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    step();
    step();
    rd = n_str;
    run_init();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
